// File: rtl/nibble_serial_adder.sv
// 16-bit adder that reuses one 4-bit add slice over four cycles, least-significant
// nibble first, with a start/busy/done handshake and signed-overflow detection.

module adder4 (
  input  logic       carryin,
  input  logic [3:0] x,
  input  logic [3:0] y,
  output logic [3:0] s,
  output logic       carryout
);
  assign {carryout, s} = {1'b0, x} + {1'b0, y} + {4'b0000, carryin};
endmodule

module nibble_serial_adder (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic        busy,
  output logic        done,
  output logic [15:0] sum,
  output logic        cout,
  output logic        ovf
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic        carry_q, carry_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [15:0] sum_q, sum_d;
  logic        cout_q, cout_d;
  logic        ovf_q, ovf_d;

  logic [3:0]  nib_a, nib_b, slice_s;
  logic        slice_co;

  // Operand nibble selected by the current index feeds the single shared slice.
  always_comb begin
    nib_a = a_q[3:0];
    nib_b = b_q[3:0];
    case (idx_q)
      2'd0: begin nib_a = a_q[3:0];   nib_b = b_q[3:0];   end
      2'd1: begin nib_a = a_q[7:4];   nib_b = b_q[7:4];   end
      2'd2: begin nib_a = a_q[11:8];  nib_b = b_q[11:8];  end
      default: begin nib_a = a_q[15:12]; nib_b = b_q[15:12]; end
    endcase
  end

  adder4 u_slice (
    .carryin  (carry_q),
    .x        (nib_a),
    .y        (nib_b),
    .s        (slice_s),
    .carryout (slice_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          sum_d   = 16'h0000;
          idx_d   = 2'd0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = slice_co;
        idx_d   = idx_q + 2'd1;
        case (idx_q)
          2'd0: sum_d[3:0]   = slice_s;
          2'd1: sum_d[7:4]   = slice_s;
          2'd2: sum_d[11:8]  = slice_s;
          default: sum_d[15:12] = slice_s;
        endcase
        if (idx_q == 2'd3) begin
          // Final sum bit 15 is the slice's top bit on this edge.
          cout_d  = slice_co;
          ovf_d   = (a_q[15] == b_q[15]) && (slice_s[3] != a_q[15]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      carry_q <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      sum_q   <= 16'h0000;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
endmodule

// File: tb/tb_nibble_serial_adder.sv
// Bench for nibble_serial_adder: directed and random adds checked against a
// plain-arithmetic reference of a+b+cin, including cycle-by-cycle partial sums.

module tb_nibble_serial_adder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        cin;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic prev_cout = 1'b0;
  logic prev_ovf  = 1'b0;

  nibble_serial_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] x, input logic [15:0] y, input logic c);
    return {1'b0, x} + {1'b0, y} + {16'h0000, c};
  endfunction

  function automatic logic ref_ovf(input logic [15:0] x, input logic [15:0] y, input logic [15:0] s);
    return (x[15] == y[15]) && (s[15] != x[15]);
  endfunction

  // One full transaction; returns at the falling edge after E5.
  task automatic run_add(input logic [15:0] av, input logic [15:0] bv, input logic ci, input bit hold);
    logic [16:0] full;
    logic        fovf;
    logic [31:0] mask;
    int          dc0;
    full = ref_add(av, bv, ci);
    fovf = ref_ovf(av, bv, full[15:0]);
    @(negedge clk);
    a = av; b = bv; cin = ci; start = 1'b1;
    dc0 = done_cnt;
    @(negedge clk);
    if (hold) begin
      a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1;
    end else begin
      start = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom);
    end
    chk("e0_busy", 32'(busy), 32'd1);
    chk("e0_done", 32'(done), 32'd0);
    chk("e0_sum",  32'(sum),  32'd0);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      mask = (32'd1 << (4 * k)) - 32'd1;
      chk("run_sum", 32'(sum), 32'(full[15:0]) & mask);
      if (k < 4) begin
        chk("run_busy", 32'(busy), 32'd1);
        chk("run_done", 32'(done), 32'd0);
        chk("run_cout_hold", 32'(cout), 32'(prev_cout));
        chk("run_ovf_hold",  32'(ovf),  32'(prev_ovf));
      end else begin
        chk("e4_busy", 32'(busy), 32'd0);
        chk("e4_done", 32'(done), 32'd1);
        chk("e4_cout", 32'(cout), 32'(full[16]));
        chk("e4_ovf",  32'(ovf),  32'(fovf));
      end
    end
    @(negedge clk);
    chk("e5_done", 32'(done), 32'd0);
    chk("e5_busy", 32'(busy), 32'd0);
    chk("e5_sum",  32'(sum),  32'(full[15:0]));
    chk("e5_cout", 32'(cout), 32'(full[16]));
    chk("done_pulses", 32'(done_cnt - dc0), 32'd1);
    prev_cout = full[16];
    prev_ovf  = fovf;
  endtask

  initial begin
    logic [16:0] full;
    logic [15:0] ra, rb, hold_sum;
    int dc0;
    rst_n = 1'b0; start = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum",  32'(sum),  32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf",  32'(ovf),  32'd0);
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b1;

    run_add(16'h1234, 16'h4321, 1'b0, 0);
    chk("v030_sum", 32'(sum), 32'h5555);
    run_add(16'hFFFF, 16'h0000, 1'b1, 0);
    chk("v031_cout", 32'(cout), 32'd1);
    run_add(16'h7FFF, 16'h0001, 1'b0, 0);
    chk("v032a_ovf", 32'(ovf), 32'd1);
    run_add(16'h8000, 16'h8000, 1'b0, 0);
    chk("v032b_sum", 32'(sum), 32'h0000);

    // Abort mid-run with an asynchronous reset.
    @(negedge clk);
    a = 16'hAAAA; b = 16'h5555; cin = 1'b0; start = 1'b1;
    dc0 = done_cnt;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_sum",  32'(sum),  32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf",  32'(ovf),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt - dc0), 32'd0);
    prev_cout = 1'b0; prev_ovf = 1'b0;
    run_add(16'h0001, 16'h0001, 1'b0, 0);
    chk("v034_sum", 32'(sum), 32'h0002);

    // start held high with operands changed mid-operation.
    run_add(16'h0F0F, 16'h0101, 1'b0, 1);
    chk("v033_sum", 32'(sum), 32'h1010);
    full = ref_add(16'hFFFF, 16'hFFFF, 1'b1);
    @(negedge clk);
    chk("v033_restart_busy", 32'(busy), 32'd1);
    chk("v033_restart_sum",  32'(sum),  32'd0);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("v033_2nd_done", 32'(done), 32'd1);
    chk("v033_2nd_sum",  32'(sum),  32'(full[15:0]));
    chk("v033_2nd_cout", 32'(cout), 32'(full[16]));
    chk("v033_2nd_ovf",  32'(ovf),  32'(ref_ovf(16'hFFFF, 16'hFFFF, full[15:0])));
    @(negedge clk);
    prev_cout = full[16];
    prev_ovf  = ref_ovf(16'hFFFF, 16'hFFFF, full[15:0]);

    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_add(ra, rb, 1'($urandom), 0);
    end

    // Idle with start low: outputs hold while inputs wander.
    hold_sum = 16'(ref_add(ra, rb, 1'b0));
    hold_sum = sum;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      a = 16'($urandom); b = 16'($urandom);
      chk("idle_sum",  32'(sum),  32'(hold_sum));
      chk("idle_busy", 32'(busy), 32'd0);
      chk("idle_done", 32'(done), 32'd0);
      chk("idle_cout", 32'(cout), 32'(prev_cout));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 The block SHALL use one clock and one reset; reset SHALL be asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to add; sampled on rising clk.
REQ-005 a  input  16  operand A, sampled only when start is accepted.
REQ-006 b  input  16  operand B, sampled only when start is accepted.
REQ-007 cin  input  1  initial carry-in, sampled only when start is accepted.
REQ-008 busy  output  1  high while a nibble addition is in progress.
REQ-009 done  output  1  one-cycle pulse marking valid sum, cout and ovf.
REQ-010 sum  output  16  registered result a+b+cin, modulo 2^16.
REQ-011 cout  output  1  carry out of bit 15.
REQ-012 ovf  output  1  two's-complement signed overflow flag.

Function
REQ-013 The datapath SHALL contain exactly one 4-bit add slice with the port set (carryin, x[3:0], y[3:0] -> s[3:0], carryout), which may be the team's existing adder4; the 16-bit add SHALL be done serially through it, least-significant nibble first.
REQ-014 The FSM SHALL have three states, IDLE, RUN and DONE, encoded in 2 bits; the unused code SHALL return to IDLE on the next edge.
REQ-015 In IDLE with start=1 on an edge, the block SHALL latch a, b and cin, clear sum to 0x0000, set the nibble index to 0, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL hold all outputs.
REQ-017 Each edge in RUN SHALL add nibble[idx] of the latched A and B plus the carry register, write the slice output to sum[4*idx+3:4*idx], store the slice carry in the carry register, and increment idx.
REQ-018 The edge on which idx=3 is processed SHALL load cout from the slice carry, load ovf, and move the FSM to DONE.
REQ-019 ovf SHALL equal (A[15]==B[15]) AND (sum[15]!=A[15]), computed from the latched operands and the final sum.
REQ-020 The next edge from DONE SHALL return the FSM to IDLE.
REQ-021 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-022 Latency: with start accepted on edge E0, nibbles SHALL be processed on E1 to E4, done SHALL be high from E4 to E5, and the FSM SHALL be back in IDLE after E5.
REQ-023 start SHALL be ignored in RUN and DONE; the operands latched at acceptance SHALL NOT change until the next accepted start.
REQ-024 sum, cout and ovf SHALL hold their final values in DONE and IDLE until the next accepted start.
REQ-025 During RUN, sum SHALL show only the nibbles written so far, with the upper nibbles still 0; cout and ovf SHALL hold their previous values until edge E4.
REQ-026 A carry that ripples across nibble boundaries SHALL propagate through the carry register with no extra cycles.

Reset
REQ-027 While rst_n=0, regardless of clk, the following SHALL be forced: state=IDLE, idx=0, carry register=0, latched operands=0, sum=0x0000, cout=0, ovf=0, busy=0, done=0.
REQ-028 Reset asserted during RUN or DONE SHALL abort the operation with no done pulse.
REQ-029 After rst_n is released, the first rising edge with start=1 SHALL be accepted normally.

Verification
REQ-030 a=0x1234, b=0x4321, cin=0, start pulse -> busy high for 4 cycles, done pulse after E4, sum=0x5555, cout=0, ovf=0.
REQ-031 a=0xFFFF, b=0x0000, cin=1 -> carry ripples through all nibbles: sum=0x0000, cout=1, ovf=0.
REQ-032 a=0x7FFF, b=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; then a=0x8000, b=0x8000, cin=0 -> sum=0x0000, cout=1, ovf=1.
REQ-033 a=0x0F0F, b=0x0101, cin=0, start held high and operands changed to 0xFFFF and 0xFFFF during RUN/DONE -> sum=0x1010, exactly one done pulse, and a second operation starts only from IDLE.
REQ-034 rst_n pulsed low after E2 of an add of 0xAAAA+0x5555 -> all outputs 0 at once, no done pulse; a new add of 0x0001+0x0001 -> sum=0x0002 with standard latency.
